subleq_prog_loader: RTL
=======================

Name: subleq_prog_loader

Overview:
Writes a program image into the subleq word memory before execution. It receives a byte stream over a valid/ready interface, assembles 16-bit words and writes them to consecutive addresses from 0. It holds the CPU in reset while loading and releases it only when the image's checksum verifies. It is the write-side counterpart of the memory dump path: it fills `mem.buffer` instead of reading it out.

Parameters:
WORD_SIZE, 16, data word width in bits (fixed to 16 for the byte-pair framing).
ADDR_WIDTH, 16, memory address width in bits.
MEM_DEPTH, 65536, number of writable words; a length above this is an error.

Ports:
clk  input  1  system clock, rising edge.
areset  input  1  synchronous active-high reset.
start  input  1  one-cycle pulse that begins a load.
rx_data  input  8  incoming image byte.
rx_valid  input  1  rx_data is valid.
rx_ready  output  1  loader accepts a byte this cycle.
mem_we  output  1  memory write strobe, one cycle per word.
mem_addr  output  ADDR_WIDTH  write address.
mem_wdata  output  WORD_SIZE  write data.
cpu_hold  output  1  keep the CPU in reset; feeds the CPU reset.
busy  output  1  a load is in progress.
done  output  1  load completed and verified; sticky until next start or reset.
error  output  1  load failed; sticky until next start or reset.
words_loaded  output  ADDR_WIDTH  count of words written in the current load.

Behaviour:
- Reset: synchronous, active-high. State goes to IDLE.
  - Outputs after reset: rx_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0, words_loaded=0, checksum=0.
  - cpu_hold=1 after reset.
- Reset mid-load aborts immediately. Partial memory contents are left as they are.
- Image framing, big-endian bytes: LEN_HI, LEN_LO, then LEN words each sent as HI then LO, then one CHK byte.
- Checksum rule: the 8-bit sum mod 256 of every byte, including both LEN bytes and CHK, must equal 0.
- A byte is accepted on a cycle where rx_valid and rx_ready are both 1. rx_ready=1 exactly in states LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHECK.
- Idle stalls (rx_valid=0) are allowed anywhere and hold state.
- State machine:
  - IDLE: cpu_hold holds its last value. start goes to LEN_HI, clears done, error, words_loaded and the checksum, sets busy=1 and cpu_hold=1.
  - LEN_HI: latch length[15:8], then go to LEN_LO.
  - LEN_LO: latch length[7:0]. If length > MEM_DEPTH, go to ERROR. If length == 0, go to CHECK. Otherwise go to DATA_HI.
  - DATA_HI: latch the high byte, then go to DATA_LO.
  - DATA_LO: on accept, register mem_wdata={hi,lo} and mem_addr=words_loaded, and pulse mem_we=1 for exactly the next cycle. Then increment words_loaded.
    - If the new words_loaded == length, go to CHECK; otherwise go to DATA_HI.
    - Write latency is one cycle after the LO byte accept. Back-to-back bytes therefore give at most one write every 2 cycles.
  - CHECK: accept the CHK byte. A final sum of 0 goes to DONE; otherwise go to ERROR.
  - DONE: done=1, busy=0, cpu_hold=0. Stays here until start or reset.
  - ERROR: error=1, busy=0, cpu_hold=1. Stays here until start or reset.
- Words already written are not rolled back on a checksum error.
- start while busy=1 is ignored. start in DONE or ERROR restarts the load and reasserts cpu_hold that cycle.
- areset takes priority over start when both are asserted together.
- mem_addr and mem_wdata hold their last values while mem_we=0.
- words_loaded never wraps: the MEM_DEPTH check bounds it. Use a length register of ADDR_WIDTH+1 bits so that length == MEM_DEPTH is legal.

Test Plan:
- Nominal load: reset, start, bytes 00 02 12 34 AB CD 40 with rx_valid held high. Expect mem_we pulses writing [0]=1234 and [1]=ABCD, then done=1, cpu_hold=0, error=0, words_loaded=2.
- Checksum failure: same stream with CHK=41. Expect both words written, then error=1, done=0, cpu_hold=1, rx_ready=0.
- Empty image: bytes 00 00 00. Expect no mem_we, done=1 and words_loaded=0 right after the CHK accept.
- Oversize, with MEM_DEPTH=256: bytes 01 01. Expect error=1 right after the LEN_LO accept, rx_ready=0 and no mem_we.
- Backpressure and restart: the nominal stream with a random rx_valid gap of 0–3 cycles between bytes gives identical writes and done. A start pulse mid-load is ignored. A start after done reasserts cpu_hold and clears done.
- Reset mid-load: assert areset after byte 4 of the nominal stream. Expect all outputs at reset values on the next edge, cpu_hold=1, and no further mem_we.

Source files
------------

// File: rtl/subleq_prog_loader.sv
// subleq_prog_loader
// Fills the subleq word memory from a framed byte stream. The frame is
// LEN_HI, LEN_LO, LEN x {HI, LO}, CHK (big-endian). The byte sum of the whole
// frame must be 0 mod 256. The CPU is kept in reset until a load verifies.
//
// Handshake: a byte moves on any rising edge where rx_valid and rx_ready are
// both 1. rx_ready depends only on the current state, never on rx_valid, and
// the sender may hold rx_valid low for any number of cycles.
module subleq_prog_loader #(
   parameter int WORD_SIZE  = 16,
   parameter int ADDR_WIDTH = 16,
   parameter int MEM_DEPTH  = 65536
) (
   input  logic                  clk,
   input  logic                  areset,
   input  logic                  start,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic                  rx_ready,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [WORD_SIZE-1:0]  mem_wdata,
   output logic                  cpu_hold,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [ADDR_WIDTH-1:0] words_loaded,
   output logic [2:0]            state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LEN_HI  = 3'd1,
      S_LEN_LO  = 3'd2,
      S_DATA_HI = 3'd3,
      S_DATA_LO = 3'd4,
      S_CHECK   = 3'd5,
      S_DONE    = 3'd6,
      S_ERROR   = 3'd7
   } state_t;

   // One extra bit so that a length equal to MEM_DEPTH is representable.
   localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(MEM_DEPTH);
   localparam logic [ADDR_WIDTH:0] ONE   = (ADDR_WIDTH+1)'(1);

   state_t                state;
   state_t                state_next;
   logic [7:0]            len_hi;
   logic [ADDR_WIDTH:0]   length;
   logic [7:0]            hi_byte;
   logic [ADDR_WIDTH:0]   count;
   logic [7:0]            checksum;
   logic                  hold_q;

   logic                  accept;
   logic                  restart;
   logic [ADDR_WIDTH:0]   len_rx;
   logic [ADDR_WIDTH:0]   count_inc;
   logic [7:0]            chk_sum;

   assign accept    = rx_valid && rx_ready;
   // start is honoured only where no load is running.
   assign restart   = start && ((state == S_IDLE) || (state == S_DONE) ||
                                (state == S_ERROR));
   assign len_rx    = (ADDR_WIDTH+1)'({len_hi, rx_data});
   assign count_inc = count + ONE;
   assign chk_sum   = checksum + rx_data;

   // Status decode straight from the state register.
   always_comb begin
      rx_ready = 1'b0;
      busy     = 1'b0;
      case (state)
         S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK: begin
            rx_ready = 1'b1;
            busy     = 1'b1;
         end
         default: begin
            rx_ready = 1'b0;
            busy     = 1'b0;
         end
      endcase
   end

   assign done         = (state == S_DONE);
   assign error        = (state == S_ERROR);
   assign words_loaded = count[ADDR_WIDTH-1:0];
   assign state_dbg    = state;
   // A restart from DONE must pull the CPU back into reset in the same cycle,
   // before the registered hold flag catches up on the next edge.
   assign cpu_hold     = hold_q || ((state == S_DONE) && start);

   // Next-state logic; every transition out of a receive state needs a byte.
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) state_next = S_LEN_HI;
         end
         S_LEN_HI: begin
            if (accept) state_next = S_LEN_LO;
         end
         S_LEN_LO: begin
            if (accept) begin
               if (len_rx > DEPTH)
                  state_next = S_ERROR;
               else if (len_rx == '0)
                  state_next = S_CHECK;
               else
                  state_next = S_DATA_HI;
            end
         end
         S_DATA_HI: begin
            if (accept) state_next = S_DATA_LO;
         end
         S_DATA_LO: begin
            if (accept) begin
               if (count_inc == length)
                  state_next = S_CHECK;
               else
                  state_next = S_DATA_HI;
            end
         end
         S_CHECK: begin
            if (accept) begin
               if (chk_sum == 8'h00)
                  state_next = S_DONE;
               else
                  state_next = S_ERROR;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // State register; reset wins over any pending start.
   always_ff @(posedge clk) begin
      if (areset)
         state <= S_IDLE;
      else
         state <= state_next;
   end

   // CPU hold flag: released only on entry to DONE, held in IDLE.
   always_ff @(posedge clk) begin
      if (areset)
         hold_q <= 1'b1;
      else if (state_next == S_DONE)
         hold_q <= 1'b0;
      else if (state_next != S_IDLE)
         hold_q <= 1'b1;
   end

   // Frame datapath: length capture, word assembly, write strobe, checksum.
   always_ff @(posedge clk) begin
      if (areset) begin
         len_hi    <= '0;
         length    <= '0;
         hi_byte   <= '0;
         count     <= '0;
         checksum  <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         mem_we <= 1'b0;
         if (restart) begin
            count    <= '0;
            checksum <= '0;
            length   <= '0;
         end else if (accept) begin
            checksum <= chk_sum;
            case (state)
               S_LEN_HI:  len_hi  <= rx_data;
               S_LEN_LO:  length  <= len_rx;
               S_DATA_HI: hi_byte <= rx_data;
               S_DATA_LO: begin
                  mem_we    <= 1'b1;
                  mem_addr  <= count[ADDR_WIDTH-1:0];
                  mem_wdata <= WORD_SIZE'({hi_byte, rx_data});
                  count     <= count_inc;
               end
               default: ;
            endcase
         end
      end
   end

endmodule
